multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main sequencing FSM for the multi-cycle RV32I core. It drives the datapath one step at a time: instruction fetch, decode, execute, memory access and writeback. It is the only block that asserts the register file's `write_enable`. It also handshakes with the unified memory, decodes ALU operations, and keeps a retired-instruction counter.

## Interface
- `OLD_PC_SEL`, default 2'b01: encoding used on `alu_src_a` for the old-PC operand. Fixed in the package; exposed for bench visibility only.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `instr` input 32: instruction register contents. Valid from DECODE onward.
- `alu_zero` input 1: ALU zero flag for the current cycle.
- `mem_ready` input 1: memory completes the current request this cycle.
- `mem_req` output 1: memory request strobe.
- `mem_we` output 1: memory write.
- `adr_src` output 1: memory address select. 0 = PC, 1 = ALU-out register.
- `ir_write` output 1: load the instruction register and old-PC register.
- `pc_write` output 1: load the PC from the result bus.
- `reg_write` output 1: register file `write_enable`.
- `alu_src_a` output 2: 00 = PC, 01 = old PC, 10 = rs1.
- `alu_src_b` output 2: 00 = rs2, 01 = immediate, 10 = constant 4.
- `result_src` output 2: 00 = ALU-out register, 01 = memory data register, 10 = ALU result.
- `alu_control` output 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `trap` output 1: illegal instruction. Sticky until reset.
- `instret` output 32: retired-instruction count.

## Operation
- States: START, FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, JAL, BRANCH, TRAP.
- Reset:
  - State goes to START and `instret` goes to 0.
  - In START every output is 0. START moves to FETCH unconditionally on the next cycle.
- FETCH:
  - Outputs: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, add, `result_src`=10.
  - Stays in FETCH until `mem_ready`.
  - In the `mem_ready` cycle, `ir_write`=`pc_write`=1, then go to DECODE.
- DECODE:
  - Outputs: `alu_src_a`=01, `alu_src_b`=01, add. This computes the branch/jump target into the ALU-out register.
  - Next state from `instr[6:0]`:
    - 0000011 and 0100011 go to MEM_ADR.
    - 0110011 goes to EXEC_R.
    - 0010011 goes to EXEC_I.
    - 1101111 goes to JAL.
    - 1100011 with funct3 000 or 001 goes to BRANCH.
    - Anything else goes to TRAP.
- MEM_ADR:
  - Outputs: `alu_src_a`=10, `alu_src_b`=01, add.
  - Next: MEM_READ if `instr[5]`=0, else MEM_WRITE.
- MEM_READ and MEM_WRITE:
  - Outputs: `mem_req`=1, `adr_src`=1. MEM_WRITE also drives `mem_we`=1.
  - Both hold until `mem_ready`.
  - MEM_READ then goes to MEM_WB. MEM_WRITE then goes to FETCH.
- MEM_WB: `result_src`=01, `reg_write`=1, then FETCH.
- EXEC_R and EXEC_I:
  - `alu_src_a`=10. `alu_src_b` is 00 in EXEC_R and 01 in EXEC_I.
  - Operation is funct-decoded. Both go to ALU_WB.
- ALU_WB: `result_src`=00, `reg_write`=1, then FETCH.
- JAL:
  - Outputs: `alu_src_a`=01, `alu_src_b`=10, add, `result_src`=00, `pc_write`=1.
  - The PC takes the target; the ALU-out register takes old PC + 4.
  - Then ALU_WB.
- BRANCH:
  - Outputs: `alu_src_a`=10, `alu_src_b`=00, sub, `result_src`=00.
  - `pc_write` = `alu_zero` XOR `funct3[0]`.
  - Then FETCH.
- TRAP: `trap`=1, all strobes 0. No exit except reset.
- ALU decode (alu_op 00 = add, 01 = sub, 10 = funct):
  - funct3 000 gives add, or sub when `op[5]`&`funct7[5]`.
  - funct3 010 gives slt, 110 gives or, 111 gives and.
  - Any other funct3 in EXEC_R or EXEC_I leads to TRAP on the next edge. No register write occurs.
- `instret`:
  - Increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB or BRANCH.
  - Wraps from 0xFFFF_FFFF to 0.

## Timing
- Outputs are Moore, decoded from the state register. Exceptions: `ir_write`/`pc_write` in FETCH and `pc_write` in BRANCH also depend on inputs.
- `reg_write` is high for one whole cycle. The register file commits on the falling edge within that cycle.
- Cycles with zero-wait memory, counting FETCH through the last state:
  - lw 5, sw 4, R-type 4, I-type 4, jal 4, branch 3.
  - Each memory wait cycle adds 1.
- The `mem_req` and address selects hold stable while waiting for `mem_ready`.
- `mem_ready` seen outside FETCH, MEM_READ or MEM_WRITE is ignored.
- Reset asserted mid-instruction aborts it immediately:
  - No further strobes are driven.
  - `instret` clears.
  - `trap` clears.

## Structure
- `control_pkg` holds:
  - the `state_e` enum;
  - opcode localparams (OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_BRANCH);
  - the mux-select and `alu_control` encodings.
- One sub-module, `alu_decoder`. It is combinational:
  - inputs: alu_op, funct3, `op[5]`, `funct7[5]`;
  - outputs: `alu_control` and an `illegal` flag.
- The FSM plus `instret` live in `multicycle_controller`.

## Test plan
- Reset then release, `mem_ready`=1, `instr`=0x002081B3 (add x3,x1,x2):
  - START, FETCH, DECODE, EXEC_R, ALU_WB, FETCH.
  - `reg_write` high in exactly one cycle; `alu_control`=000; `instret`=1.
- `instr`=0x0000A183 (lw), with `mem_ready` low for 3 cycles in FETCH and 2 cycles in MEM_READ:
  - 10 cycles in total.
  - `mem_req`/`adr_src` stable throughout the waits.
  - `reg_write` asserted only in MEM_WB with `result_src`=01.
- `instr`=0x00208463 (beq):
  - With `alu_zero`=1: `pc_write`=1 in BRANCH.
  - With `alu_zero`=0: `pc_write`=0.
  - Repeat with bne (0x00209463); the results are inverted.
- `instr`=0xFFFFFFFF: TRAP after DECODE, `trap`=1 sticky, no `mem_req` for 20 cycles, `instret` unchanged.
- Drop `rst_n` in MEM_WRITE while `mem_ready`=0:
  - All outputs are 0 asynchronously.
  - After release: one START cycle, then FETCH.
- Force `instret` to 0xFFFF_FFFF via backdoor, then retire one `addi` (0x00100093): `instret`=0.

Source files
------------

// File: rtl/control_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package control_pkg;

  typedef enum logic [3:0] {
    START, FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE,
    EXEC_R, EXEC_I, ALU_WB, JAL, BRANCH, TRAP
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Where DECODE goes for a given opcode; only beq/bne are supported branches.
  function automatic state_e decode_next(input logic [6:0] opcode, input logic [2:0] funct3);
    state_e nxt;
    case (opcode)
      OP_LOAD, OP_STORE: nxt = MEM_ADR;
      OP_R:              nxt = EXEC_R;
      OP_I:              nxt = EXEC_I;
      OP_JAL:            nxt = JAL;
      OP_BRANCH:         nxt = (funct3[2:1] == 2'b00) ? BRANCH : TRAP;
      default:           nxt = TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from alu_op and instruction funct fields.
// Latency: purely combinational.
// Backpressure: none; illegal_o flags unsupported funct3 encodings.
module alu_decoder
  import control_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7_5_i,
  output logic [2:0] alu_control_o,
  output logic       illegal_o
);

  // Select the ALU operation; unsupported funct3 reports illegal and falls back to add.
  always_comb begin
    alu_control_o = ALU_ADD;
    illegal_o     = 1'b0;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i & funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: illegal_o = 1'b1;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main sequencing FSM of the multi-cycle RV32I core plus retired-instruction counter.
// Latency: lw 5, sw/R/I/jal 4, branch 3 cycles with zero-wait memory.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold with stable selects until mem_ready.
module multicycle_controller
  import control_pkg::*;
#(
  parameter logic [1:0] OLD_PC_SEL = SRC_A_OLDPC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [2:0]  alu_control,
  output logic        trap,
  output logic [31:0] instret
);

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic [1:0]  alu_op;
  logic        alu_illegal;
  logic        retire;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
  assign instret      = instret_q;

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .op5_i         (instr[5]),
    .funct7_5_i    (instr[30]),
    .alu_control_o (alu_control),
    .illegal_o     (alu_illegal)
  );

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= START;
    else        state_q <= state_d;
  end

  // Retired-instruction counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= 32'd0;
    else        instret_q <= instret_d;
  end

  // Count one retirement per completed instruction.
  always_comb begin
    instret_d = retire ? instret_q + 32'd1 : instret_q;
  end

  // Next-state and datapath controls; outputs are Moore except the noted strobes.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    result_src = RES_ALUOUT;
    alu_op     = ALUOP_ADD;
    trap       = 1'b0;
    retire     = 1'b0;
    case (state_q)
      START: state_d = FETCH;
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        // Precompute the branch/jump target into the ALU-out register.
        alu_src_a = OLD_PC_SEL;
        alu_src_b = SRC_B_IMM;
        state_d   = decode_next(opcode, funct3);
      end
      MEM_ADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = instr[5] ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = MEM_WB;
      end
      MEM_WRITE: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      MEM_WB: begin
        result_src = RES_MDR;
        reg_write  = 1'b1;
        state_d    = FETCH;
        retire     = 1'b1;
      end
      EXEC_R, EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = (state_q == EXEC_I) ? SRC_B_IMM : SRC_B_RS2;
        alu_op    = ALUOP_FUNCT;
        state_d   = alu_illegal ? TRAP : ALU_WB;
      end
      ALU_WB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_d    = FETCH;
        retire     = 1'b1;
      end
      JAL: begin
        // PC takes the target computed in DECODE; ALU-out takes old PC + 4 as the link.
        alu_src_a  = OLD_PC_SEL;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_d    = ALU_WB;
      end
      BRANCH: begin
        // funct3[0] distinguishes bne from beq and inverts the taken condition.
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = alu_zero ^ funct3[0];
        state_d    = FETCH;
        retire     = 1'b1;
      end
      TRAP: trap = 1'b1;
      default: state_d = START;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: vector table, corner sequences, random stream.
// Latency: observed per instruction as cycles from FETCH entry to the next FETCH.
// Backpressure: memory wait states are injected per phase through mem_ready.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        alu_zero;
  logic        mem_ready;
  logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, trap;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  alu_control;
  logic [31:0] instret;
  logic [15:0] outs;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret;

  typedef struct {
    int         cycles;
    int         regw;
    int         pcw;
    int         mwe;
    logic [2:0] alu;
    logic [1:0] rs;
    logic       trap;
  } res_t;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    int          fw;
    int          mw;
    res_t        e;
  } vec_t;

  vec_t vecs[21];

  multicycle_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .alu_zero    (alu_zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .result_src  (result_src),
    .alu_control (alu_control),
    .trap        (trap),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  assign outs = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                 alu_src_a, alu_src_b, result_src, alu_control, trap};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference behaviour of one instruction, from the ISA-level rules.
  function automatic res_t model(input logic [31:0] i, input logic z, input int fw, input int mw);
    res_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    logic       alu_ok;
    op     = i[6:0];
    f3     = i[14:12];
    e      = '{fw, 0, 1, 0, 3'b111, 2'b11, 1'b0};
    alu_ok = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    if (op == 7'b0000011) begin
      e.cycles += 5 + mw; e.regw = 1; e.rs = 2'b01; e.alu = 3'b000;
    end else if (op == 7'b0100011) begin
      e.cycles += 4 + mw; e.mwe = mw + 1; e.alu = 3'b000;
    end else if (op == 7'b0110011 || op == 7'b0010011) begin
      if (!alu_ok) begin
        e.cycles += 3; e.alu = 3'b000; e.trap = 1'b1;
      end else begin
        e.cycles += 4; e.regw = 1; e.rs = 2'b00;
        case (f3)
          3'b000:  e.alu = (op[5] && i[30]) ? 3'b001 : 3'b000;
          3'b010:  e.alu = 3'b101;
          3'b110:  e.alu = 3'b011;
          default: e.alu = 3'b010;
        endcase
      end
    end else if (op == 7'b1101111) begin
      e.cycles += 4; e.regw = 1; e.rs = 2'b00; e.pcw = 2;
    end else if (op == 7'b1100011 && f3[2:1] == 2'b00) begin
      e.cycles += 3; e.alu = 3'b001; e.pcw = (z ^ f3[0]) ? 2 : 1;
    end else begin
      e.cycles += 2; e.trap = 1'b1;
    end
    return e;
  endfunction

  // Called with rst_n low: release just after a clock edge, expect one START cycle then FETCH.
  task automatic release_and_check();
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_instret = 32'd0;
    mem_ready = 1'b0;
    @(negedge clk);
    check("start outputs", 32'(outs), 32'd0);
    check("start instret", instret, 32'd0);
    @(negedge clk);
    check("fetch after start", 32'({mem_req, adr_src}), 32'b10);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    release_and_check();
  endtask

  // Entered at the negedge of a FETCH cycle; returns at the negedge of the next FETCH or on trap.
  task automatic run_instr(input logic [31:0] i, input logic z, input int fw, input int mw,
                           output res_t r);
    int   fc = 0;
    int   mc = 0;
    logic prev_fetch = 1'b0;
    logic is_fetch;
    bit   done = 1'b0;
    instr = i;
    alu_zero = z;
    r = '{0, 0, 0, 0, 3'b111, 2'b11, 1'b0};
    while (!done) begin
      is_fetch = mem_req && !adr_src;
      if (trap) begin
        r.trap = 1'b1;
        done = 1'b1;
      end else if (r.cycles > 0 && is_fetch && !prev_fetch) begin
        done = 1'b1;
      end else if (r.cycles >= 100) begin
        check("instruction timeout", 32'(r.cycles), 32'd0);
        done = 1'b1;
      end else begin
        if (is_fetch) begin
          mem_ready = (fc == fw); fc++;
        end else if (mem_req) begin
          mem_ready = (mc == mw); mc++;
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
        end
        #1;
        if (reg_write) begin r.regw++; r.rs = result_src; end
        if (pc_write) r.pcw++;
        if (mem_we) r.mwe++;
        if (alu_src_a == 2'b10) r.alu = alu_control;
        prev_fetch = is_fetch;
        r.cycles++;
        @(negedge clk);
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic apply(input string tag, input logic [31:0] i, input logic z, input int fw,
                       input int mw, input res_t e);
    res_t r;
    run_instr(i, z, fw, mw, r);
    check({tag, " cycles"}, 32'(r.cycles), 32'(e.cycles));
    check({tag, " reg_write"}, 32'(r.regw), 32'(e.regw));
    check({tag, " pc_write"}, 32'(r.pcw), 32'(e.pcw));
    check({tag, " mem_we"}, 32'(r.mwe), 32'(e.mwe));
    check({tag, " alu_control"}, 32'(r.alu), 32'(e.alu));
    check({tag, " result_src"}, 32'(r.rs), 32'(e.rs));
    check({tag, " trap"}, 32'(r.trap), 32'(e.trap));
    if (!e.trap) exp_instret = exp_instret + 32'd1;
    check({tag, " instret"}, instret, exp_instret);
    if (r.trap || e.trap) do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t e;
    int   bad;
    int   k;
    logic [31:0] ri;
    logic rz;
    int   fw, mw;

    //          instr         z     fw mw  cyc rw pw mwe alu     rs     trap
    vecs[0]  = '{32'h002081B3, 1'b0, 0, 0, '{4, 1, 1, 0, 3'b000, 2'b00, 1'b0}}; // add
    vecs[1]  = '{32'h40208233, 1'b0, 0, 0, '{4, 1, 1, 0, 3'b001, 2'b00, 1'b0}}; // sub
    vecs[2]  = '{32'h0020A233, 1'b0, 0, 0, '{4, 1, 1, 0, 3'b101, 2'b00, 1'b0}}; // slt
    vecs[3]  = '{32'h0020E233, 1'b0, 0, 0, '{4, 1, 1, 0, 3'b011, 2'b00, 1'b0}}; // or
    vecs[4]  = '{32'h0020F233, 1'b0, 0, 0, '{4, 1, 1, 0, 3'b010, 2'b00, 1'b0}}; // and
    vecs[5]  = '{32'h00100093, 1'b0, 0, 0, '{4, 1, 1, 0, 3'b000, 2'b00, 1'b0}}; // addi
    vecs[6]  = '{32'h40100093, 1'b0, 0, 0, '{4, 1, 1, 0, 3'b000, 2'b00, 1'b0}}; // addi, bit30 set
    vecs[7]  = '{32'h00102093, 1'b0, 0, 0, '{4, 1, 1, 0, 3'b101, 2'b00, 1'b0}}; // slti
    vecs[8]  = '{32'h0000A183, 1'b0, 0, 0, '{5, 1, 1, 0, 3'b000, 2'b01, 1'b0}}; // lw
    vecs[9]  = '{32'h0000A183, 1'b0, 3, 2, '{10, 1, 1, 0, 3'b000, 2'b01, 1'b0}}; // lw + waits
    vecs[10] = '{32'h0020A223, 1'b0, 1, 2, '{7, 0, 1, 3, 3'b000, 2'b11, 1'b0}}; // sw + waits
    vecs[11] = '{32'h008000EF, 1'b0, 0, 0, '{4, 1, 2, 0, 3'b111, 2'b00, 1'b0}}; // jal
    vecs[12] = '{32'h00208463, 1'b1, 0, 0, '{3, 0, 2, 0, 3'b001, 2'b11, 1'b0}}; // beq taken
    vecs[13] = '{32'h00208463, 1'b0, 0, 0, '{3, 0, 1, 0, 3'b001, 2'b11, 1'b0}}; // beq not taken
    vecs[14] = '{32'h00209463, 1'b1, 0, 0, '{3, 0, 1, 0, 3'b001, 2'b11, 1'b0}}; // bne not taken
    vecs[15] = '{32'h00209463, 1'b0, 0, 0, '{3, 0, 2, 0, 3'b001, 2'b11, 1'b0}}; // bne taken
    vecs[16] = '{32'hFFFFFFFF, 1'b0, 0, 0, '{2, 0, 1, 0, 3'b111, 2'b11, 1'b1}}; // bad opcode
    vecs[17] = '{32'h00209233, 1'b0, 0, 0, '{3, 0, 1, 0, 3'b000, 2'b11, 1'b1}}; // sll unsupported
    vecs[18] = '{32'h0020C463, 1'b0, 0, 0, '{2, 0, 1, 0, 3'b111, 2'b11, 1'b1}}; // blt unsupported
    vecs[19] = '{32'h00101093, 1'b0, 0, 0, '{3, 0, 1, 0, 3'b000, 2'b11, 1'b1}}; // slli unsupported
    vecs[20] = '{32'h008000EF, 1'b0, 2, 0, '{6, 1, 2, 0, 3'b111, 2'b00, 1'b0}}; // jal + waits

    rst_n = 1'b0;
    instr = 32'd0;
    alu_zero = 1'b0;
    mem_ready = 1'b0;
    exp_instret = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset outputs", 32'(outs), 32'd0);
    check("reset instret", instret, 32'd0);
    release_and_check();

    for (int v = 0; v < 21; v++)
      apply($sformatf("vec%0d", v), vecs[v].instr, vecs[v].zero, vecs[v].fw, vecs[v].mw, vecs[v].e);

    // Illegal instruction: trap stays set, no memory traffic, no retirement.
    e = model(32'hFFFFFFFF, 1'b0, 0, 0);
    begin
      res_t r;
      run_instr(32'hFFFFFFFF, 1'b0, 0, 0, r);
      check("trap entered", 32'(r.trap), 32'(e.trap));
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (mem_req || !trap || instret !== exp_instret) bad++;
      @(negedge clk);
    end
    check("trap sticky bad cycles", 32'(bad), 32'd0);
    do_reset();

    // Reset while a store waits on memory.
    apply("pre-abort add", 32'h002081B3, 1'b0, 0, 0, model(32'h002081B3, 1'b0, 0, 0));
    instr = 32'h0020A223;
    k = 0;
    while (!mem_we && k < 20) begin
      mem_ready = mem_req && !adr_src;
      @(negedge clk);
      k++;
    end
    mem_ready = 1'b0;
    check("store reached mem_write", 32'(mem_we), 32'd1);
    @(posedge clk);
    #2;
    check("store holds without ready", 32'({mem_req, adr_src, mem_we}), 32'b111);
    rst_n = 1'b0;
    #1;
    check("abort outputs", 32'(outs), 32'd0);
    check("abort instret", instret, 32'd0);
    release_and_check();

    // Randomized instruction stream against the reference model.
    for (int n = 0; n < 200; n++) begin
      ri = $urandom;
      rz = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      case ($urandom_range(0, 7))
        0: ri[6:0] = 7'b0000011;
        1: ri[6:0] = 7'b0100011;
        2: ri[6:0] = 7'b0110011;
        3: ri[6:0] = 7'b0010011;
        4: ri[6:0] = 7'b1101111;
        5: ri[6:0] = 7'b1100011;
        6: ri[6:0] = 7'($urandom_range(0, 127));
        default: begin
          ri[6:0] = 7'b0110011;
          ri[14:12] = 3'b000;
        end
      endcase
      apply($sformatf("rnd%0d", n), ri, rz, fw, mw, model(ri, rz, fw, mw));
    end

    // Counter wrap: preload all-ones, then retire one addi.
    dut.instret_q = 32'hFFFF_FFFF;
    exp_instret = 32'hFFFF_FFFF;
    apply("wrap addi", 32'h00100093, 1'b0, 0, 0, model(32'h00100093, 1'b0, 0, 0));
    check("instret wrapped", instret, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
